// File: rtl/caxi4interconnect_slave_resp_control_if.sv
// Bus bundle for the slave-port response controller: address handshake, response
// handshake, routing outputs and status.
interface caxi4interconnect_slave_resp_control_if #(
    parameter int NUM_MASTERS_WIDTH = 2,
    parameter int MASTERID_WIDTH    = 4,
    parameter int OPEN_TRANS_WIDTH  = 2
);
    logic                         addrValid;
    logic                         addrReady;
    logic [MASTERID_WIDTH-1:0]    addrID;
    logic                         addrQual;
    logic                         respValid;
    logic                         respReady;
    logic                         respLast;
    logic [MASTERID_WIDTH-1:0]    respID;
    logic [NUM_MASTERS_WIDTH-1:0] respMasterSel;
    logic                         respMasterValid;
    logic [OPEN_TRANS_WIDTH-1:0]  openCount;
    logic                         errUnexpected;

    modport slave (
        input  addrValid, addrReady, addrID, respValid, respReady, respLast, respID,
        output addrQual, respMasterSel, respMasterValid, openCount, errUnexpected
    );

    modport master (
        output addrValid, addrReady, addrID, respValid, respReady, respLast, respID,
        input  addrQual, respMasterSel, respMasterValid, openCount, errUnexpected
    );
endinterface

// File: rtl/caxi4interconnect_slave_resp_control.sv
// Outstanding-ID table for one slave port; routes responses back to the issuing master.
// Optional sticky unexpected-response flag enabled by CAXI4INTERCONNECT_SLAVE_RESP_ERRCHK_EN.
module caxi4interconnect_slave_resp_control #(
    parameter int NUM_MASTERS_WIDTH = 2,
    parameter int MASTERID_WIDTH    = 4,
    parameter int OPEN_TRANS_MAX    = 3,
    parameter int OPEN_TRANS_WIDTH  = 2
) (
    input logic sysClk,
    input logic sysReset,
    caxi4interconnect_slave_resp_control_if.slave bus
);
    localparam logic [OPEN_TRANS_WIDTH-1:0] COUNT_FULL = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
    localparam logic [OPEN_TRANS_WIDTH-1:0] COUNT_ONE  = OPEN_TRANS_WIDTH'(1);

    logic [OPEN_TRANS_MAX-1:0]   entryValid;
    logic [MASTERID_WIDTH-1:0]   entryId [OPEN_TRANS_MAX];
    logic [OPEN_TRANS_WIDTH-1:0] openCountReg;
    logic [OPEN_TRANS_MAX-1:0]   matchVec;
    logic [OPEN_TRANS_MAX-1:0]   allocVec;
    logic [OPEN_TRANS_MAX-1:0]   relVec;
    logic                        anyMatch;
    logic                        addrQualInt;
    logic                        doAlloc;
    logic                        doRel;

    always_comb begin
        for (int i = 0; i < OPEN_TRANS_MAX; i++) begin
            matchVec[i] = entryValid[i] && (entryId[i] == bus.respID);
        end
    end

    assign anyMatch = |matchVec;

    // Both selections look only at the registered table, so a same-cycle release
    // never hands its slot to the allocation happening alongside it.
    always_comb begin
        logic freeFound;
        logic relFound;
        allocVec  = '0;
        relVec    = '0;
        freeFound = 1'b0;
        relFound  = 1'b0;
        for (int i = 0; i < OPEN_TRANS_MAX; i++) begin
            if (!freeFound && !entryValid[i]) begin
                allocVec[i] = 1'b1;
                freeFound   = 1'b1;
            end
            if (!relFound && matchVec[i]) begin
                relVec[i] = 1'b1;
                relFound  = 1'b1;
            end
        end
    end

    assign addrQualInt = (openCountReg != COUNT_FULL);
    assign doAlloc     = bus.addrValid && bus.addrReady && addrQualInt && (|allocVec);
    assign doRel       = bus.respValid && bus.respReady && bus.respLast && anyMatch;

    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            entryValid <= '0;
            for (int i = 0; i < OPEN_TRANS_MAX; i++) begin
                entryId[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OPEN_TRANS_MAX; i++) begin
                if (doAlloc && allocVec[i]) begin
                    entryValid[i] <= 1'b1;
                    entryId[i]    <= bus.addrID;
                end else if (doRel && relVec[i]) begin
                    entryValid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            openCountReg <= '0;
        end else begin
            case ({doAlloc, doRel})
                2'b10: if (openCountReg != COUNT_FULL) openCountReg <= openCountReg + COUNT_ONE;
                2'b01: if (openCountReg != '0)         openCountReg <= openCountReg - COUNT_ONE;
                default: ;
            endcase
        end
    end

    assign bus.addrQual        = addrQualInt;
    assign bus.openCount       = openCountReg;
    assign bus.respMasterSel   = bus.respID[MASTERID_WIDTH-1 -: NUM_MASTERS_WIDTH];
    assign bus.respMasterValid = bus.respValid && anyMatch;

`ifdef CAXI4INTERCONNECT_SLAVE_RESP_ERRCHK_EN
    logic errSticky;

    // Any accepted beat without an outstanding owner is flagged, last or not.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            errSticky <= 1'b0;
        end else if (bus.respValid && bus.respReady && !anyMatch) begin
            errSticky <= 1'b1;
        end
    end

    assign bus.errUnexpected = errSticky;
`else
    assign bus.errUnexpected = 1'b0;
`endif
endmodule

// File: tb/tb_caxi4interconnect_slave_resp_control.sv
// Scoreboard bench for the slave-port response controller: expected count/qual pushed
// with each stimulus cycle, popped and compared after the clock edge.
module tb_caxi4interconnect_slave_resp_control;
    logic sysClk = 1'b0;
    logic sysReset = 1'b0;
    always #5 sysClk = ~sysClk;

    caxi4interconnect_slave_resp_control_if #(
        .NUM_MASTERS_WIDTH(2), .MASTERID_WIDTH(4), .OPEN_TRANS_WIDTH(2)
    ) bus ();

    caxi4interconnect_slave_resp_control #(
        .NUM_MASTERS_WIDTH(2), .MASTERID_WIDTH(4), .OPEN_TRANS_MAX(3), .OPEN_TRANS_WIDTH(2)
    ) dut (
        .sysClk  (sysClk),
        .sysReset(sysReset),
        .bus     (bus)
    );

    typedef struct {
        string      tag;
        logic [1:0] cnt;
        logic       qual;
    } exp_t;

    typedef struct {
        string      tag;
        logic       av;
        logic [3:0] aid;
        logic       rv;
        logic       rr;
        logic       rl;
        logic [3:0] rid;
        logic [1:0] cnt;
        logic       qual;
    } step_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic expErr;

    task automatic drive(input logic av, input logic [3:0] aid, input logic rv,
                         input logic rr, input logic rl, input logic [3:0] rid);
        bus.addrValid = av;
        bus.addrReady = av;
        bus.addrID    = aid;
        bus.respValid = rv;
        bus.respReady = rr;
        bus.respLast  = rl;
        bus.respID    = rid;
    endtask

    task automatic tick;
        @(posedge sysClk);
        #1;
    endtask

    // Drives one cycle of stimulus and queues what the registered outputs must show after it.
    task automatic apply(input step_t s);
        drive(s.av, s.aid, s.rv, s.rr, s.rl, s.rid);
        sbq.push_back('{s.tag, s.cnt, s.qual});
        tick();
        drive(0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    task automatic test_reset;
        drive(0, 4'h0, 1, 0, 0, 4'h5);
        #1;
        checks++;
        if ({bus.addrQual, bus.openCount, bus.respMasterValid, bus.errUnexpected} !== 5'b1_00_0_0) begin
            errors++;
            $display("FAIL reset: qual/cnt/rmv/err=%b expected 10000",
                     {bus.addrQual, bus.openCount, bus.respMasterValid, bus.errUnexpected});
        end
        tick();
        tick();
        sysReset = 1'b1;
        drive(0, 4'h0, 0, 0, 0, 4'h0);
        tick();
    endtask

    task automatic test_single;
        exp_t e;
        apply('{"single_alloc", 1, 4'h5, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
            errors++;
            $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
        end
        drive(0, 4'h0, 1, 0, 0, 4'h5);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b1 || bus.respMasterSel !== 2'd1) begin
            errors++;
            $display("FAIL single_route: rmv=%0b sel=%0d expected 1/1", bus.respMasterValid, bus.respMasterSel);
        end
        apply('{"single_release", 0, 4'h0, 1, 1, 1, 4'h5, 2'd0, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
            errors++;
            $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
        end
    endtask

    task automatic test_fill;
        exp_t e;
        for (int i = 1; i <= 4; i++) begin
            apply('{$sformatf("fill_%0d", i), 1, 4'(i), 0, 0, 0, 4'h0,
                    (i > 3) ? 2'd3 : 2'(i), (i < 3) ? 1'b1 : 1'b0});
            e = sbq.pop_front();
            checks++;
            if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
                errors++;
                $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
            end
        end
        drive(0, 4'h0, 1, 0, 0, 4'h4);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b0) begin
            errors++;
            $display("FAIL fill_ignored_id4: rmv=%0b expected 0", bus.respMasterValid);
        end
        drive(0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    task automatic test_full_release;
        exp_t e;
        step_t steps[$];
        logic [3:0] ids[4] = '{4'h7, 4'h2, 4'h1, 4'h3};
        logic       rmv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        apply('{"full_rel", 1, 4'h7, 1, 1, 1, 4'h2, 2'd2, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
            errors++;
            $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'h0, 1, 0, 0, ids[i]);
            #1;
            checks++;
            if (bus.respMasterValid !== rmv[i]) begin
                errors++;
                $display("FAIL full_probe_id%0h: rmv=%0b expected %0b", ids[i], bus.respMasterValid, rmv[i]);
            end
        end
        steps.push_back('{"drain_id1", 0, 4'h0, 1, 1, 1, 4'h1, 2'd1, 1'b1});
        steps.push_back('{"drain_id3", 0, 4'h0, 1, 1, 1, 4'h3, 2'd0, 1'b1});
        steps.push_back('{"realloc_id1", 1, 4'h1, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        foreach (steps[k]) begin
            apply(steps[k]);
            e = sbq.pop_front();
            checks++;
            if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
                errors++;
                $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
            end
        end
    endtask

    task automatic test_same_id;
        exp_t e;
        apply('{"same_cycle_id1", 1, 4'h1, 1, 1, 1, 4'h1, 2'd1, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
            errors++;
            $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
        end
        drive(0, 4'h0, 1, 0, 0, 4'h1);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_probe: rmv=%0b expected 1", bus.respMasterValid);
        end
        apply('{"same_cycle_final", 0, 4'h0, 1, 1, 1, 4'h1, 2'd0, 1'b1});
        e = sbq.pop_front();
        drive(0, 4'h0, 1, 0, 0, 4'h1);
        #1;
        checks++;
        if (bus.openCount !== e.cnt || bus.respMasterValid !== 1'b0) begin
            errors++;
            $display("FAIL %s: openCount=%0d rmv=%0b expected %0d/0", e.tag, bus.openCount, bus.respMasterValid, e.cnt);
        end
        drive(0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    task automatic test_multi_beat;
        exp_t e;
        apply('{"beat_alloc", 1, 4'h3, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        void'(sbq.pop_front());
        drive(0, 4'h0, 1, 1, 0, 4'h3);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b1 || bus.respMasterSel !== 2'd0) begin
            errors++;
            $display("FAIL beat_route: rmv=%0b sel=%0d expected 1/0", bus.respMasterValid, bus.respMasterSel);
        end
        for (int b = 1; b <= 4; b++) begin
            apply('{$sformatf("beat_%0d", b), 0, 4'h0, 1, 1, (b == 4), 4'h3,
                    (b == 4) ? 2'd0 : 2'd1, 1'b1});
            e = sbq.pop_front();
            checks++;
            if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
                errors++;
                $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
            end
        end
    endtask

    task automatic test_dup_ids;
        exp_t e;
        step_t steps[$];
        steps.push_back('{"dup_alloc_a", 1, 4'h9, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        steps.push_back('{"dup_alloc_b", 1, 4'h9, 0, 0, 0, 4'h0, 2'd2, 1'b1});
        steps.push_back('{"dup_rel_a",   0, 4'h0, 1, 1, 1, 4'h9, 2'd1, 1'b1});
        foreach (steps[k]) begin
            apply(steps[k]);
            e = sbq.pop_front();
            checks++;
            if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
                errors++;
                $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
            end
        end
        drive(0, 4'h0, 1, 0, 0, 4'h9);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b1 || bus.respMasterSel !== 2'd2) begin
            errors++;
            $display("FAIL dup_remaining: rmv=%0b sel=%0d expected 1/2", bus.respMasterValid, bus.respMasterSel);
        end
        apply('{"dup_rel_b", 0, 4'h0, 1, 1, 1, 4'h9, 2'd0, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
            errors++;
            $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        step_t steps[$];
        steps.push_back('{"b2b_alloc_a", 1, 4'hA, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        steps.push_back('{"b2b_alloc_b", 1, 4'hB, 0, 0, 0, 4'h0, 2'd2, 1'b1});
        steps.push_back('{"b2b_alloc_c", 1, 4'hC, 0, 0, 0, 4'h0, 2'd3, 1'b0});
        steps.push_back('{"b2b_stalled", 0, 4'h0, 1, 0, 1, 4'hA, 2'd3, 1'b0});
        steps.push_back('{"b2b_rel_b",   0, 4'h0, 1, 1, 1, 4'hB, 2'd2, 1'b1});
        steps.push_back('{"b2b_rel_a",   1, 4'h6, 1, 1, 1, 4'hA, 2'd2, 1'b1});
        steps.push_back('{"b2b_rel_c",   0, 4'h0, 1, 1, 1, 4'hC, 2'd1, 1'b1});
        steps.push_back('{"b2b_rel_6",   0, 4'h0, 1, 1, 1, 4'h6, 2'd0, 1'b1});
        foreach (steps[k]) begin
            apply(steps[k]);
            e = sbq.pop_front();
            checks++;
            if (bus.openCount !== e.cnt || bus.addrQual !== e.qual) begin
                errors++;
                $display("FAIL %s: openCount=%0d addrQual=%0b expected %0d/%0b", e.tag, bus.openCount, bus.addrQual, e.cnt, e.qual);
            end
        end
    endtask

    task automatic test_unexpected;
        exp_t e;
        drive(0, 4'h0, 1, 0, 0, 4'hC);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b0 || bus.errUnexpected !== 1'b0) begin
            errors++;
            $display("FAIL unexp_probe: rmv=%0b err=%0b expected 0/0", bus.respMasterValid, bus.errUnexpected);
        end
        apply('{"unexp_resp", 0, 4'h0, 1, 1, 1, 4'hC, 2'd0, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.errUnexpected !== expErr) begin
            errors++;
            $display("FAIL %s: openCount=%0d err=%0b expected %0d/%0b", e.tag, bus.openCount, bus.errUnexpected, e.cnt, expErr);
        end
        tick();
        tick();
        checks++;
        if (bus.errUnexpected !== expErr) begin
            errors++;
            $display("FAIL unexp_sticky: err=%0b expected %0b", bus.errUnexpected, expErr);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        apply('{"mid_alloc", 1, 4'h5, 0, 0, 0, 4'h0, 2'd1, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt) begin
            errors++;
            $display("FAIL %s: openCount=%0d expected %0d", e.tag, bus.openCount, e.cnt);
        end
        #2;
        sysReset = 1'b0;
        #1;
        checks++;
        if (bus.openCount !== 2'd0 || bus.errUnexpected !== 1'b0 || bus.addrQual !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: cnt=%0d err=%0b qual=%0b expected 0/0/1", bus.openCount, bus.errUnexpected, bus.addrQual);
        end
        tick();
        sysReset = 1'b1;
        drive(0, 4'h0, 1, 0, 0, 4'h5);
        #1;
        checks++;
        if (bus.respMasterValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_discarded: rmv=%0b expected 0", bus.respMasterValid);
        end
        apply('{"mid_late_resp", 0, 4'h0, 1, 1, 1, 4'h5, 2'd0, 1'b1});
        e = sbq.pop_front();
        checks++;
        if (bus.openCount !== e.cnt || bus.errUnexpected !== expErr) begin
            errors++;
            $display("FAIL %s: openCount=%0d err=%0b expected %0d/%0b", e.tag, bus.openCount, bus.errUnexpected, e.cnt, expErr);
        end
    endtask

    initial begin
`ifdef CAXI4INTERCONNECT_SLAVE_RESP_ERRCHK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        drive(0, 4'h0, 0, 0, 0, 4'h0);
        test_reset();
        test_single();
        test_fill();
        test_full_release();
        test_same_id();
        test_multi_beat();
        test_dup_ids();
        test_back_to_back();
        test_unexpected();
        test_reset_mid();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/caxi4interconnect_slave_resp_control.md
CAXI4INTERCONNECT_SLAVE_RESP_CONTROL -- requirements
Module: caxi4interconnect_slave_resp_control

Interface
REQ-001 SHALL have parameter NUM_MASTERS_WIDTH, default 2, bits encoding master port index (upper bits of ID).
REQ-002 SHALL have parameter MASTERID_WIDTH, default 4, full transaction ID width (master index + requestor ID).
REQ-003 SHALL have parameter OPEN_TRANS_MAX, default 3, max outstanding transactions at this slave port.
REQ-004 SHALL have parameter OPEN_TRANS_WIDTH, default 2, width of open count; holds 0..OPEN_TRANS_MAX.
REQ-005 SHALL have port sysClk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port sysReset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port addrValid  input  1  address request presented to slave.
REQ-008 SHALL have port addrReady  input  1  slave accepts address.
REQ-009 SHALL have port addrID  input  MASTERID_WIDTH  ID of presented address.
REQ-010 SHALL have port addrQual  output  1  high = slave port may accept new address.
REQ-011 SHALL have port respValid  input  1  slave response valid.
REQ-012 SHALL have port respReady  input  1  master side accepts response.
REQ-013 SHALL have port respLast  input  1  final beat of response.
REQ-014 SHALL have port respID  input  MASTERID_WIDTH  ID on response.
REQ-015 SHALL have port respMasterSel  output  NUM_MASTERS_WIDTH  master port to route response to.
REQ-016 SHALL have port respMasterValid  output  1  respValid qualified by ID being outstanding.
REQ-017 SHALL have port openCount  output  OPEN_TRANS_WIDTH  outstanding transaction count.
REQ-018 SHALL have port errUnexpected  output  1  sticky: response seen with no matching outstanding ID.

Function
REQ-019 SHALL hold a table of OPEN_TRANS_MAX entries, each {valid, ID}.
REQ-020 SHALL allocate the lowest-index free entry with addrID on addrValid&addrReady&addrQual; entry valid next cycle.
REQ-021 SHALL release, on respValid&respReady&respLast, the lowest-index valid entry whose ID equals respID.
REQ-022 SHALL NOT release an entry on non-last response beats.
REQ-023 SHALL maintain openCount as registered count: +1 on allocate, -1 on release, unchanged when both occur same cycle.
REQ-024 SHALL drive addrQual = (openCount != OPEN_TRANS_MAX), combinational from registered count; a same-cycle release while full does not raise addrQual until next cycle.
REQ-025 SHALL ignore address handshakes while addrQual low (no allocation, no count change).
REQ-026 SHALL drive respMasterSel = respID[MASTERID_WIDTH-1 -: NUM_MASTERS_WIDTH] combinationally.
REQ-027 SHALL drive respMasterValid = respValid & (any valid entry matches respID), combinationally, zero latency.
REQ-028 SHALL allow allocation and release of the same ID in one cycle; release acts on pre-existing entry, allocation on a free entry.
REQ-029 SHALL support multiple entries with identical ID; each last-beat release frees exactly one.
REQ-030 SHALL keep openCount saturating-safe: never exceed OPEN_TRANS_MAX, never wrap below 0.

Reset
REQ-031 SHALL on sysReset low asynchronously clear all entry valid bits, openCount=0, errUnexpected=0; addrQual=1, respMasterValid=0 while in reset.
REQ-032 SHALL discard all outstanding entries on reset mid-operation; responses arriving after release of reset are unexpected.

Configuration
REQ-033 SHALL use macro CAXI4INTERCONNECT_SLAVE_RESP_ERRCHK_EN: defined -> errUnexpected set on respValid&respReady with no matching valid entry, held until reset; undefined -> errUnexpected tied 0, no match-check logic for error, table behaviour unchanged.

Verification
REQ-034 SHALL verify: reset, addr ID 0x5 accepted -> next cycle openCount=1, respMasterValid on respID 0x5 =1, respMasterSel=1.
REQ-035 SHALL verify: 3 addresses IDs 0x1,0x2,0x3 -> openCount=3, addrQual=0; 4th addrValid&addrReady -> no allocation, count stays 3.
REQ-036 SHALL verify: full, last-beat response ID 0x2 and addr ID 0x7 same cycle -> addr ignored, count=2 next cycle, addrQual=1.
REQ-037 SHALL verify: count=1, same-cycle release ID 0x1 and allocate ID 0x1 -> count stays 1, one entry ID 0x1 valid.
REQ-038 SHALL verify: 4-beat response ID 0x3, respLast only on beat 4 -> count decrements only after beat 4.
REQ-039 SHALL verify with macro defined: response ID 0xC with empty table -> respMasterValid=0, errUnexpected=1 until reset; macro undefined -> errUnexpected stays 0.
